// File: rtl/dac_pkg.sv
// ============================================================================
// Module   : dac_pkg
// Purpose  : Shared constants, state encoding and frame builder for the
//            serial DAC write scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dac_pkg;

  // FSM encoding
  localparam logic [2:0] PWRUP = 3'd0;
  localparam logic [2:0] IDLE  = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  localparam logic [3:0] CMD_WRITE        = 4'b0000;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_POWER        = 4'b0100;

  // Power-up of all channels; the low byte is the channel-enable mask.
  localparam logic [31:0] PWRUP_FRAME = {4'h0, CMD_POWER, 24'h0000FF};

  function automatic logic [31:0] mk_frame(input logic [3:0] cmd,
                                           input logic [3:0] addr,
                                           input logic [11:0] code);
    return {4'b0000, cmd, addr, code, 8'h00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dac_rr_arbiter.sv
// ============================================================================
// Module   : dac_rr_arbiter
// Purpose  : Combinational round-robin pick; search starts at rrPointer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dac_rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] reqValid,
  input  logic [2:0]        rrPointer,
  output logic [NUM_CH-1:0] grant,
  output logic [2:0]        grantIdx,
  output logic              anyValid
);

  logic [7:0] w_reqPad;
  logic [7:0] w_grantPad;

  assign w_reqPad = 8'(reqValid);
  assign grant    = w_grantPad[NUM_CH-1:0];

  always_comb begin
    int         cand;
    logic [2:0] candIdx;
    w_grantPad = '0;
    grantIdx   = '0;
    anyValid   = 1'b0;
    cand       = 0;
    candIdx    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = int'(rrPointer) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      candIdx = 3'(cand);
      if (!anyValid && w_reqPad[candIdx]) begin
        anyValid            = 1'b1;
        w_grantPad[candIdx] = 1'b1;
        grantIdx            = candIdx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dac_write_scheduler.sv
// ============================================================================
// Module   : dac_write_scheduler
// Purpose  : Shares one serial DAC link among NUM_CH requesters; sends a
//            power-up frame after reset, then serves writes round-robin.
//            Optional macro DAC_SIMUL_UPDATE_EN: write-only frames plus one
//            ldacN pulse per arbitration round.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dac_write_scheduler
  import dac_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CODE_W    = 12,
  parameter int FRAME_LEN = 32,
  parameter int SYNC_GAP  = 2
) (
  input  logic                     dacSerialClock,
  input  logic                     resetN,
  input  logic [NUM_CH-1:0]        reqValid,
  input  logic [NUM_CH*CODE_W-1:0] reqCode,
  output logic [NUM_CH-1:0]        reqAck,
  output logic                     syncN,
  output logic                     dIn,
  output logic                     ldacN,
  output logic                     busy,
  output logic [2:0]               grantIdx
);

  localparam logic [4:0] c_BIT_LAST = 5'(FRAME_LEN - 1);
  localparam logic [7:0] c_GAP_LAST = 8'(SYNC_GAP - 1);
  localparam logic [2:0] c_LAST_CH  = 3'(NUM_CH - 1);
`ifdef DAC_SIMUL_UPDATE_EN
  localparam logic [3:0] c_CMD = CMD_WRITE;
`else
  localparam logic [3:0] c_CMD = CMD_WRITE_UPDATE;
`endif

  logic [2:0]        r_state;
  logic              r_syncN;
  logic              r_dIn;
  logic [NUM_CH-1:0] r_reqAck;
  logic [2:0]        r_grantIdx;
  logic [2:0]        r_rrPtr;
  logic [31:0]       r_shift;
  logic [4:0]        r_bitCnt;
  logic [7:0]        r_gapCnt;

  logic [NUM_CH-1:0] w_grant;
  logic [2:0]        w_grantIdx;
  logic              w_anyValid;
  logic [CODE_W-1:0] w_code;
  logic [31:0]       w_frame;

  dac_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .reqValid  (reqValid),
    .rrPointer (r_rrPtr),
    .grant     (w_grant),
    .grantIdx  (w_grantIdx),
    .anyValid  (w_anyValid)
  );

  always_comb begin
    w_code = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grantIdx == 3'(i)) w_code = reqCode[i*CODE_W +: CODE_W];
    end
  end

  assign w_frame = mk_frame(c_CMD, {1'b0, w_grantIdx}, w_code);

  always_ff @(posedge dacSerialClock) begin
    if (!resetN) begin
      r_state    <= PWRUP;
      r_syncN    <= 1'b1;
      r_dIn      <= 1'b0;
      r_reqAck   <= '0;
      r_grantIdx <= '0;
      r_rrPtr    <= '0;
      r_shift    <= '0;
      r_bitCnt   <= c_BIT_LAST;
      r_gapCnt   <= '0;
    end else begin
      r_reqAck <= '0;
      case (r_state)
        // PWRUP shares the shifter; its first cycle (syncN still high) loads it.
        PWRUP, SHIFT: begin
          if (r_state == PWRUP && r_syncN) begin
            r_syncN  <= 1'b0;
            r_dIn    <= PWRUP_FRAME[31];
            r_shift  <= {PWRUP_FRAME[30:0], 1'b0};
            r_bitCnt <= c_BIT_LAST;
          end else if (r_bitCnt == 5'd0) begin
            r_syncN  <= 1'b1;
            r_dIn    <= 1'b0;
            r_gapCnt <= c_GAP_LAST;
            r_state  <= GAP;
          end else begin
            r_dIn    <= r_shift[31];
            r_shift  <= {r_shift[30:0], 1'b0};
            r_bitCnt <= r_bitCnt - 5'd1;
          end
        end
        IDLE: begin
          if (w_anyValid) r_state <= LOAD;
        end
        LOAD: begin
          if (w_anyValid) begin
            r_grantIdx <= w_grantIdx;
            r_rrPtr    <= (w_grantIdx == c_LAST_CH) ? 3'd0 : w_grantIdx + 3'd1;
            r_reqAck   <= w_grant;
            r_syncN    <= 1'b0;
            r_dIn      <= w_frame[31];
            r_shift    <= {w_frame[30:0], 1'b0};
            r_bitCnt   <= c_BIT_LAST;
            r_state    <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        GAP: begin
          if (r_gapCnt == 8'd0) r_state <= IDLE;
          else                  r_gapCnt <= r_gapCnt - 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DAC_SIMUL_UPDATE_EN
  logic r_ldacN;
  logic r_roundWrap;

  // A round closes on pointer wrap or when nobody is waiting as the frame ends.
  always_ff @(posedge dacSerialClock) begin
    if (!resetN) begin
      r_ldacN     <= 1'b1;
      r_roundWrap <= 1'b0;
    end else begin
      r_ldacN <= 1'b1;
      if (r_state == LOAD && w_anyValid) r_roundWrap <= (w_grantIdx == c_LAST_CH);
      if (r_state == SHIFT && r_bitCnt == 5'd0 && (r_roundWrap || !(|reqValid)))
        r_ldacN <= 1'b0;
    end
  end

  assign ldacN = r_ldacN;
`else
  assign ldacN = 1'b1;
`endif

  assign syncN    = r_syncN;
  assign dIn      = r_dIn;
  assign reqAck   = r_reqAck;
  assign grantIdx = r_grantIdx;
  assign busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dac_write_scheduler.sv
// ============================================================================
// Module   : tb_dac_write_scheduler
// Purpose  : Self-checking bench for dac_write_scheduler (directed table,
//            corner sequences and randomized requesters vs. a reference model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dac_write_scheduler;

  localparam int NUM_CH   = 4;
  localparam int SYNC_GAP = 2;
`ifdef DAC_SIMUL_UPDATE_EN
  localparam logic [3:0] EXP_CMD     = 4'h0;
  localparam int         LDAC_SINGLE = 1;
`else
  localparam logic [3:0] EXP_CMD     = 4'h3;
  localparam int         LDAC_SINGLE = 0;
`endif

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [3:0]  reqValid = '0;
  logic [47:0] reqCode = '0;
  logic [3:0]  reqAck;
  logic        syncN, dIn, ldacN, busy;
  logic [2:0]  grantIdx;

  dac_write_scheduler u_dut (
    .dacSerialClock (clk),
    .resetN         (resetN),
    .reqValid       (reqValid),
    .reqCode        (reqCode),
    .reqAck         (reqAck),
    .syncN          (syncN),
    .dIn            (dIn),
    .ldacN          (ldacN),
    .busy           (busy),
    .grantIdx       (grantIdx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] frameQ[$];
  int          lenQ[$];
  int          gapQ[$];
  logic [3:0]  ackQ[$];
  int          ldacCount = 0;
  logic [31:0] capWord = '0;
  int          capLen = 0;
  int          gapLen = 0;
  int          lastGap = 0;

  typedef struct {
    int          ch;
    logic [11:0] code;
    logic [31:0] frame;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [31:0] mkExp(input int addr, input logic [11:0] code);
    return {4'h0, EXP_CMD, 4'(addr), code, 8'h00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // One clock: sample at negedge and rebuild frames from the serial pins.
  task automatic step();
    @(negedge clk);
    if (syncN == 1'b0) begin
      if (capLen == 0) lastGap = gapLen;
      capWord = {capWord[30:0], dIn};
      capLen++;
    end else begin
      if (capLen != 0) begin
        frameQ.push_back(capWord);
        lenQ.push_back(capLen);
        gapQ.push_back(lastGap);
        capLen = 0;
        gapLen = 0;
      end
      gapLen++;
    end
    if (reqAck != '0) ackQ.push_back(reqAck);
    if (ldacN == 1'b0) ldacCount++;
  endtask

  task automatic clearObs();
    frameQ.delete(); lenQ.delete(); gapQ.delete(); ackQ.delete();
    ldacCount = 0;
  endtask

  task automatic waitAcks(input int n, input int bound, input string name);
    int k = 0;
    while (ackQ.size() < n && k < bound) begin step(); k++; end
    if (ackQ.size() < n) timeoutFail(name);
  endtask

  task automatic waitFrames(input int n, input int bound, input string name);
    int k = 0;
    while (frameQ.size() < n && k < bound) begin step(); k++; end
    if (frameQ.size() < n) timeoutFail(name);
  endtask

  task automatic waitIdle(input int bound, input string name);
    int k = 0;
    while (busy !== 1'b0 && k < bound) begin step(); k++; end
    if (busy !== 1'b0) timeoutFail(name);
  endtask

  task automatic resetAndPowerUp(input string name);
    resetN = 1'b0;
    reqValid = '0;
    step(); step();
    capLen = 0; gapLen = 0;
    clearObs();
    resetN = 1'b1;
    waitFrames(1, 80, {name, " pwrup"});
    if (frameQ.size() > 0) begin
      chk({name, " pwrup frame"}, frameQ[0], 32'h0400_00FF);
      chk({name, " pwrup len"}, 32'(lenQ[0]), 32'd32);
    end
    waitIdle(20, {name, " pwrup idle"});
    clearObs();
  endtask

  task automatic single(input int ch, input logic [11:0] code, input logic [31:0] exp,
                        input string name);
    clearObs();
    reqValid[ch] = 1'b1;
    reqCode[ch*12 +: 12] = code;
    waitAcks(1, 20, {name, " ack wait"});
    if (ackQ.size() > 0) begin
      chk({name, " ack"}, 32'(ackQ[0]), 32'(4'b0001 << ch));
      chk({name, " grantIdx"}, 32'(grantIdx), 32'(ch));
    end
    reqValid[ch] = 1'b0;
    waitFrames(1, 60, {name, " frame wait"});
    waitIdle(20, {name, " idle"});
    if (frameQ.size() > 0) begin
      chk({name, " frame"}, frameQ[0], exp);
      chk({name, " len"}, 32'(lenQ[0]), 32'd32);
    end
    chk({name, " ack count"}, 32'(ackQ.size()), 32'd1);
    chk({name, " ldac pulses"}, 32'(ldacCount), 32'(LDAC_SINGLE));
  endtask

  task automatic randomTest(input int cycles);
    logic [31:0] expQ[$];
    logic [3:0]  aV;
    logic [47:0] aC;
    int          mPtr;
    int          w;
    int          c;
    int          k;
    logic [31:0] f;
    bit          draining;
    mPtr = 0;
    draining = 1'b0;
    k = 0;
    while (k < cycles + 2000 && (k < cycles || reqValid != '0 || busy !== 1'b0)) begin
      draining = (k >= cycles);
      aV = reqValid;
      aC = reqCode;
      step();
      k++;
      if (reqAck != '0) begin
        w = -1;
        for (int j = 0; j < NUM_CH; j++) begin
          c = (mPtr + j) % NUM_CH;
          if (w < 0 && aV[c]) w = c;
        end
        if (w < 0) begin
          timeoutFail("rand spurious ack");
        end else begin
          chk("rand ack", 32'(reqAck), 32'(4'b0001 << w));
          expQ.push_back(mkExp(w, aC[w*12 +: 12]));
          mPtr = (w + 1) % NUM_CH;
        end
      end
      while (frameQ.size() > 0) begin
        f = frameQ.pop_front();
        if (expQ.size() == 0) begin
          total++; bad++;
          $display("FAIL rand frame: got %h expected none", f);
        end else begin
          chk("rand frame", f, expQ.pop_front());
        end
        chk("rand len", 32'(lenQ.pop_front()), 32'd32);
        chk("rand gap ok", 32'(gapQ.pop_front() >= SYNC_GAP), 32'd1);
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (reqAck[ch]) begin
          if (draining || $urandom_range(1, 0) == 0) reqValid[ch] = 1'b0;
          else reqCode[ch*12 +: 12] = 12'($urandom);
        end else if (!reqValid[ch]) begin
          if (!draining && $urandom_range(3, 0) == 0) begin
            reqValid[ch] = 1'b1;
            reqCode[ch*12 +: 12] = 12'($urandom);
          end
        end else if ($urandom_range(9, 0) == 0) begin
          reqCode[ch*12 +: 12] = 12'($urandom);
        end
      end
    end
    chk("rand all served", 32'(reqValid), 32'd0);
    chk("rand frames outstanding", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int k;
    vecs[0] = '{0, 12'hABC, 32'h030A_BC00};
    vecs[1] = '{1, 12'h123, 32'h0311_2300};
    vecs[2] = '{3, 12'hFFF, 32'h033F_FF00};
    vecs[3] = '{2, 12'h000, 32'h0320_0000};
    vecs[4] = '{3, 12'h5A5, 32'h0335_A500};

    // Reset state
    step(); step();
    chk("rst syncN", 32'(syncN), 32'd1);
    chk("rst dIn", 32'(dIn), 32'd0);
    chk("rst ldacN", 32'(ldacN), 32'd1);
    chk("rst reqAck", 32'(reqAck), 32'd0);
    chk("rst busy", 32'(busy), 32'd1);
    chk("rst grantIdx", 32'(grantIdx), 32'd0);

    // Power-up frame, then idle
    resetAndPowerUp("boot");

    // Single-requester table
    for (int i = 0; i < 5; i++) begin
      single(vecs[i].ch, vecs[i].code,
             {vecs[i].frame[31:28], EXP_CMD, vecs[i].frame[23:0]},
             $sformatf("vec%0d", i));
    end

    // All four held from pointer 0: order 0,1,2,3,0
    clearObs();
    reqCode  = {12'h444, 12'h333, 12'h222, 12'h111};
    reqValid = 4'hF;
    waitAcks(5, 400, "rr ack wait");
    reqValid = '0;
    waitFrames(5, 100, "rr frame wait");
    waitIdle(20, "rr idle");
    chk("rr ack count", 32'(ackQ.size()), 32'd5);
    for (int i = 0; i < 5 && i < ackQ.size() && i < frameQ.size(); i++) begin
      chk($sformatf("rr ack%0d", i), 32'(ackQ[i]), 32'(4'b0001 << (i % 4)));
      chk($sformatf("rr frame%0d", i), frameQ[i],
          mkExp(i % 4, 12'h111 * 12'((i % 4) + 1)));
      if (i > 0) chk($sformatf("rr gap%0d", i), 32'(gapQ[i] >= SYNC_GAP), 32'd1);
    end

    // One-cycle pulse on ch2 during a frame is never served
    clearObs();
    reqValid[0] = 1'b1;
    reqCode[11:0] = 12'h777;
    waitAcks(1, 20, "pulse ack wait");
    reqValid[0] = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reqValid[2] = 1'b1;
    step();
    reqValid[2] = 1'b0;
    waitFrames(1, 60, "pulse frame wait");
    waitIdle(20, "pulse idle");
    for (int i = 0; i < 10; i++) step();
    chk("pulse acks", 32'(ackQ.size()), 32'd1);
    chk("pulse frames", 32'(frameQ.size()), 32'd1);
    if (ackQ.size() > 0) chk("pulse ack ch0", 32'(ackQ[0]), 32'd1);

    // Reset in the middle of a frame
    clearObs();
    reqValid[1] = 1'b1;
    reqCode[23:12] = 12'h999;
    waitAcks(1, 20, "midrst ack wait");
    k = 0;
    while (capLen < 16 && k < 40) begin step(); k++; end
    if (capLen < 16) timeoutFail("midrst bit wait");
    resetN = 1'b0;
    step();
    chk("midrst syncN", 32'(syncN), 32'd1);
    chk("midrst dIn", 32'(dIn), 32'd0);
    chk("midrst busy", 32'(busy), 32'd1);
    reqValid = '0;
    step();
    capLen = 0; gapLen = 0;
    clearObs();
    resetN = 1'b1;
    waitFrames(1, 80, "midrst pwrup wait");
    if (frameQ.size() > 0) begin
      chk("midrst pwrup frame", frameQ[0], 32'h0400_00FF);
      chk("midrst pwrup len", 32'(lenQ[0]), 32'd32);
    end
    waitIdle(20, "midrst idle");

    // Requests on ch1 and ch2 from a fresh pointer
    clearObs();
    reqCode[23:12] = 12'h111;
    reqCode[35:24] = 12'h222;
    reqValid = 4'b0110;
    waitAcks(1, 20, "dual ack1 wait");
    reqValid[1] = 1'b0;
    waitFrames(1, 60, "dual frame1 wait");
    chk("dual ldac mid", 32'(ldacCount), 32'd0);
    waitAcks(2, 40, "dual ack2 wait");
    reqValid[2] = 1'b0;
    waitFrames(2, 60, "dual frame2 wait");
    waitIdle(20, "dual idle");
    if (ackQ.size() >= 2 && frameQ.size() >= 2) begin
      chk("dual ack1", 32'(ackQ[0]), 32'b0010);
      chk("dual ack2", 32'(ackQ[1]), 32'b0100);
      chk("dual frame1", frameQ[0], mkExp(1, 12'h111));
      chk("dual frame2", frameQ[1], mkExp(2, 12'h222));
    end
    chk("dual ldac total", 32'(ldacCount), 32'(LDAC_SINGLE));

    // Randomized requesters against the reference model
    resetAndPowerUp("rand");
    randomTest(4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
